// File: rtl/sa_vc_local_if.sv
// Signal bundle between one router input port's VC buffers, its local switch
// allocator stage and the switch-traversal pipeline register.
interface sa_vc_local_if #(
    parameter int N = 5,
    parameter int V = 4
);
    logic [V-1:0]   vc_valid;
    logic [V*N-1:0] vc_route;
    logic [V-1:0]   vc_credit;
    logic [V-1:0]   vc_tail;
    logic           inputGrantSA;
    logic [N-1:0]   reqSA;
    logic [V-1:0]   winVC;
    logic [V-1:0]   vc_dequeue;
    logic           st_valid;
    logic [V-1:0]   st_vc;
    logic [N-1:0]   st_port;

    modport slave (
        input  vc_valid, vc_route, vc_credit, vc_tail, inputGrantSA,
        output reqSA, winVC, vc_dequeue, st_valid, st_vc, st_port
    );

    modport master (
        output vc_valid, vc_route, vc_credit, vc_tail, inputGrantSA,
        input  reqSA, winVC, vc_dequeue, st_valid, st_vc, st_port
    );
endinterface

// File: rtl/sa_vc_local.sv
// Local (per input port) round-robin VC selection for switch allocation.
// Define SA_LOCK_EN to hold the port on one VC for a whole packet.
module sa_vc_local #(
    parameter int N = 5,
    parameter int V = 4
) (
    input  logic          clk,
    input  logic          rstn,
    sa_vc_local_if.slave  bus
);
    localparam int IW = (V > 1) ? $clog2(V) : 1;

    logic [V-1:0]  ptr;
    logic [V-1:0]  eligible;
    logic [V-1:0]  win;
    logic [N-1:0]  req;
    logic          grant_ok;
    logic          ptr_adv;
    logic [IW-1:0] ptr_idx;
    logic          st_valid_q;
    logic [V-1:0]  st_vc_q;
    logic [N-1:0]  st_port_q;

    function automatic logic is_onehot(input logic [N-1:0] r);
        return (r != '0) && ((r & (r - N'(1))) == '0);
    endfunction

`ifdef SA_LOCK_EN
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]   state;
    logic [V-1:0] lock_vc;
    logic         win_tail;
`endif

    always_comb begin
        eligible = '0;
        for (int i = 0; i < V; i++) begin
            eligible[i] = bus.vc_valid[i] & bus.vc_credit[i] &
                          is_onehot(bus.vc_route[i*N +: N]);
        end
`ifdef SA_LOCK_EN
        // Mid-packet, only the locked VC may compete; if it stalls the port idles.
        if (state == LOCKED) begin
            eligible = eligible & lock_vc;
        end
`endif
    end

    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < V; i++) begin
            if (ptr[i]) begin
                ptr_idx = IW'(i);
            end
        end
    end

    // Search upward from the priority pointer with wrap-around; first hit wins.
    always_comb begin
        int  idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < V; k++) begin
            idx = int'(ptr_idx) + k;
            if (idx >= V) begin
                idx = idx - V;
            end
            if (!found && eligible[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        req = '0;
        for (int i = 0; i < V; i++) begin
            if (win[i]) begin
                req = req | bus.vc_route[i*N +: N];
            end
        end
    end

    assign grant_ok = bus.inputGrantSA & (|win);

`ifdef SA_LOCK_EN
    assign win_tail = |(win & bus.vc_tail);
    // Priority only rotates once a packet has completely left the port.
    assign ptr_adv  = grant_ok & win_tail;
`else
    assign ptr_adv  = grant_ok;
`endif

    always_ff @(posedge clk) begin
        if (rstn) begin
            ptr        <= V'(1);
            st_valid_q <= 1'b0;
            st_vc_q    <= '0;
            st_port_q  <= '0;
        end else begin
            st_valid_q <= grant_ok;
            st_vc_q    <= grant_ok ? win : '0;
            st_port_q  <= grant_ok ? req : '0;
            if (ptr_adv) begin
                ptr <= {win[V-2:0], win[V-1]};
            end
        end
    end

`ifdef SA_LOCK_EN
    always_ff @(posedge clk) begin
        if (rstn) begin
            state   <= IDLE;
            lock_vc <= '0;
        end else if (grant_ok) begin
            case (state)
                IDLE: begin
                    if (!win_tail) begin
                        state   <= LOCKED;
                        lock_vc <= win;
                    end
                end
                LOCKED: begin
                    if (win_tail) begin
                        state   <= IDLE;
                        lock_vc <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    lock_vc <= '0;
                end
            endcase
        end
    end
`endif

    assign bus.reqSA      = req;
    assign bus.winVC      = win;
    assign bus.vc_dequeue = grant_ok ? win : '0;
    assign bus.st_valid   = st_valid_q;
    assign bus.st_vc      = st_vc_q;
    assign bus.st_port    = st_port_q;
endmodule

// File: doc/sa_vc_local.md
SA_VC_LOCAL -- requirements
Module: sa_vc_local

Interface
REQ-001 SHALL have parameter N, default `N (5), number of router ports / width of port one-hot vectors.
REQ-002 SHALL have parameter V, default 4, number of VCs per input port.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-high (1 = reset asserted).
REQ-005 SHALL have port vc_valid  input  V  VC i holds a head-of-queue flit with output VC already allocated.
REQ-006 SHALL have port vc_route  input  V*N  one-hot output port of VC i at bits [i*N +: N].
REQ-007 SHALL have port vc_credit  input  V  downstream VC of VC i has at least one credit.
REQ-008 SHALL have port vc_tail  input  V  head-of-queue flit of VC i is a tail flit.
REQ-009 SHALL have port inputGrantSA  input  1  this port won main switch allocation this cycle.
REQ-010 SHALL have port reqSA  output  N  one-hot output-port request to main allocator, 0 = no request.
REQ-011 SHALL have port winVC  output  V  one-hot local winner VC, combinational.
REQ-012 SHALL have port vc_dequeue  output  V  one-hot pop pulse to input buffer, equal to winVC when inputGrantSA=1, else 0.
REQ-013 SHALL have port st_valid  output  1  registered: switch traversal flit valid next stage.
REQ-014 SHALL have ports st_vc  output  V  and st_port  output  N  registered winner VC and output port for switch traversal.

Function
REQ-015 VC i SHALL be eligible iff vc_valid[i] & vc_credit[i] & popcount(vc_route[i])==1; multi-hot or zero routes are ineligible.
REQ-016 Local arbitration SHALL be round-robin: winVC = first eligible VC searching upward (with wrap V-1 -> 0) from one-hot priority pointer ptr; winVC=0 if none eligible.
REQ-017 reqSA SHALL equal vc_route of winVC, or 0 when winVC=0; reqSA and winVC SHALL be combinational, zero-cycle from inputs.
REQ-018 On a cycle with inputGrantSA=1 and winVC!=0, ptr SHALL become winVC rotated left by one (winner gets lowest priority next cycle); otherwise ptr holds.
REQ-019 inputGrantSA=1 while reqSA=0 SHALL be ignored: no ptr/state change, vc_dequeue=0, st_valid=0 next cycle.
REQ-020 st_valid/st_vc/st_port SHALL register (1, winVC, reqSA) one cycle after a valid grant; otherwise st_valid=0 and st_vc/st_port=0.
REQ-021 Eligibility change between request and grant in the same cycle SHALL not occur (grant is combinational on reqSA); no internal request holding.

Reset
REQ-022 While rstn=1 at a clock edge: ptr=VC0 (one-hot bit 0), st_valid=0, st_vc=0, st_port=0, lock FSM (if compiled) = IDLE.
REQ-023 Reset mid-packet SHALL discard any lock; combinational outputs SHALL follow inputs with reset-state ptr during and after reset.

Configuration
REQ-024 Macro SA_LOCK_EN SHALL select packet-level locking; without it arbitration is per flit and no lock state exists.
REQ-025 With SA_LOCK_EN: FSM states IDLE, LOCKED, register lock_vc (V bits); IDLE->LOCKED, lock_vc=winVC on valid grant of non-tail flit; LOCKED->IDLE on valid grant of tail flit from lock_vc; single-flit packet (head=tail) stays IDLE.
REQ-026 With SA_LOCK_EN in LOCKED: only lock_vc may be eligible; if it is ineligible (e.g. no credit) reqSA=0 and state remains LOCKED; ptr SHALL update only on the LOCKED->IDLE grant or an IDLE tail grant.

Verification
REQ-027 Reset, then all 4 VCs eligible, routes 00001/00010/00100/01000, inputGrantSA=1 every cycle -> winVC 0001,0010,0100,1000,0001; st_port follows one cycle later.
REQ-028 VC1,VC3 eligible, ptr=VC2, inputGrantSA=0 for 3 cycles -> winVC=1000, reqSA=VC3 route constant, ptr unchanged, st_valid=0.
REQ-029 VC0 valid, vc_credit[0]=0 -> reqSA=0; set credit -> reqSA=route0 same cycle; VC2 route 00011 -> never wins.
REQ-030 inputGrantSA=1 with no eligible VC -> vc_dequeue=0, next st_valid=0, ptr unchanged.
REQ-031 SA_LOCK_EN: VC0 3-flit packet, VC1 eligible, grant each cycle -> VC0,VC0,VC0 then VC1; drop vc_credit[0] mid-packet -> reqSA=0, VC1 never wins until VC0 tail granted.
REQ-032 SA_LOCK_EN: assert rstn while LOCKED on VC2 -> next cycle IDLE, ptr=VC0, st_valid=0; VC1 eligible -> wins immediately.
